// File: rtl/alarm_display_pkg.sv
// Shared types and constants for the alarm display arbiter: the FSM state
// encoding and the display PIO register address.
package alarm_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

endpackage

// File: rtl/alarm_display_arbiter_if.sv
// Avalon-MM link between the arbiter (master) and the display PIO (slave).
// The PIO has no waitrequest: the write completes in the cycle it is issued,
// and av_readdata is valid combinationally in the same cycle as the address.
interface alarm_display_arbiter_if #(
  parameter int DATA_W = 32
);

  logic [1:0]        av_address;
  logic              av_chipselect;
  logic              av_write_n;
  logic [DATA_W-1:0] av_writedata;
  logic [DATA_W-1:0] av_readdata;

  modport master (
    output av_address,
    output av_chipselect,
    output av_write_n,
    output av_writedata,
    input  av_readdata
  );

  modport slave (
    input  av_address,
    input  av_chipselect,
    input  av_write_n,
    input  av_writedata,
    output av_readdata
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin selector. A lone request is served directly; with both
// pending, the requester not served last wins. Requester 0 wins first after reset.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       gnt_idx_o,
  output logic       last_o
);

  // prio_q names the requester that wins a tie on the next selection.
  logic prio_q;
  logic prio_d;

  always_comb begin
    gnt_idx_o = 1'b0;
    if (req_i == 2'b10)      gnt_idx_o = 1'b1;
    else if (req_i == 2'b11) gnt_idx_o = prio_q;

    prio_d = prio_q;
    if (advance_i && (|req_i)) prio_d = ~gnt_idx_o;
  end

  always_ff @(posedge clk) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  assign last_o = ~prio_q;

endmodule

// File: rtl/alarm_display_arbiter.sv
// Arbitrates timekeeper (0) and alarm-set UI (1) writes to the display PIO,
// reading each word back to detect display write failures.
module alarm_display_arbiter
  import alarm_display_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  // req/gnt: req is held with stable data until the one-cycle gnt pulse;
  // a request is committed once sampled in IDLE, even if req later drops.
  input  logic                    req0,
  input  logic                    req1,
  input  logic [DATA_W-1:0]       data0,
  input  logic [DATA_W-1:0]       data1,
  output logic                    gnt0,
  output logic                    gnt1,
  alarm_display_arbiter_if.master av,
  output logic                    err,
  output logic [CNT_W-1:0]        err_count,
  input  logic                    err_clr,
  output logic                    owner,
  output state_t                  dbg_state_o,
  output logic                    dbg_rr_last_o
);

  state_t            state_q;
  logic              sel_q;
  logic [DATA_W-1:0] word_q;
  logic [1:0]        gnt_q;
  logic              cs_q;
  logic              wn_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              owner_q;

  logic              sel_idx_d;
  logic              any_req_d;
  logic              advance_d;
  logic              mismatch_d;
  logic [DATA_W-1:0] sel_data_d;

  assign any_req_d  = req0 | req1;
  assign advance_d  = (state_q == ST_IDLE) && any_req_d;
  assign sel_data_d = sel_idx_d ? data1 : data0;
  assign mismatch_d = (state_q == ST_READ) && (av.av_readdata != word_q);

  rr_arbiter_2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_i     ({req1, req0}),
    .advance_i (advance_d),
    .gnt_idx_o (sel_idx_d),
    .last_o    (dbg_rr_last_o)
  );

  // Bus outputs are registered for the state being entered, so the write
  // appears in the cycle after the request is sampled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= 1'b0;
      word_q  <= '0;
      gnt_q   <= 2'b00;
      cs_q    <= 1'b0;
      wn_q    <= 1'b1;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
    end else begin
      gnt_q <= 2'b00;
      case (state_q)
        ST_IDLE: begin
          if (any_req_d) begin
            sel_q   <= sel_idx_d;
            word_q  <= sel_data_d;
            cs_q    <= 1'b1;
            wn_q    <= 1'b0;
            wdata_q <= sel_data_d;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wn_q    <= 1'b1;
          wdata_q <= '0;
          state_q <= ST_READ;
        end
        ST_READ: begin
          cs_q    <= 1'b0;
          gnt_q   <= sel_q ? 2'b10 : 2'b01;
          owner_q <= sel_q;
          state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      // Clear takes priority over a mismatch landing in the same cycle.
      if (err_clr) begin
        err_q <= 1'b0;
        cnt_q <= '0;
      end else if (mismatch_d) begin
        err_q <= 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign gnt0             = gnt_q[0];
  assign gnt1             = gnt_q[1];
  assign av.av_address    = PIO_DATA_ADDR;
  assign av.av_chipselect = cs_q;
  assign av.av_write_n    = wn_q;
  assign av.av_writedata  = wdata_q;
  assign err              = err_q;
  assign err_count        = cnt_q;
  assign owner            = owner_q;
  assign dbg_state_o      = state_q;

endmodule
